ld3320_reset_seq: RTL and testbench

//   Parametrised power-up/re-init sequencer for the LD3320 voice chip. On request it drives RST low
//   for a programmable pulse, then a recovery interval, then a CSB high pulse, and reports completion.

---
 rtl/ld3320_pkg.sv | 40 ++++
 rtl/ld3320_reset_seq_if.sv | 11 +
 rtl/ld3320_phase_cnt.sv | 29 ++
 rtl/ld3320_reset_seq.sv | 95 +++++++++
 tb/tb_ld3320_reset_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ld3320_pkg.sv
// Shared LD3320 reset-sequencer types: FSM state encoding, default phase timings
// and the registered pin bundle with its per-state decode.
package ld3320_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSERT   = 3'd1,
    RECOVER  = 3'd2,
    CS_PULSE = 3'd3,
    DONE     = 3'd4
  } ld3320_state_e;

  localparam int LD3320_T_RST_LOW  = 4;
  localparam int LD3320_T_RECOVER  = 4;
  localparam int LD3320_T_CSB_HIGH = 2;

  typedef struct packed {
    logic rst;
    logic csb;
    logic busy;
    logic done;
  } ld3320_pins_t;

  localparam ld3320_pins_t LD3320_PINS_IDLE = '{rst: 1'b1, csb: 1'b0, busy: 1'b0, done: 1'b0};

  // Pin levels for a state; anything unrecognised gets the idle levels.
  function automatic ld3320_pins_t ld3320_decode(ld3320_state_e s);
    ld3320_pins_t p;
    p = LD3320_PINS_IDLE;
    case (s)
      ASSERT:   begin p.rst = 1'b0; p.busy = 1'b1; end
      RECOVER:  p.busy = 1'b1;
      CS_PULSE: begin p.csb = 1'b1; p.busy = 1'b1; end
      DONE:     p.done = 1'b1;
      default:  p = LD3320_PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ld3320_reset_seq_if.sv
// Controller <-> reset sequencer bundle: start request, status and the chip pins.
interface ld3320_reset_seq_if;
  logic ena;
  logic RST;
  logic CSB;
  logic busy;
  logic done;

  modport master (output ena, input RST, CSB, busy, done);
  modport slave  (input ena, output RST, CSB, busy, done);
endinterface

// File: rtl/ld3320_phase_cnt.sv
// Phase duration counter: clears on request, counts while enabled, flags the
// last cycle of a phase (count == limit-1).
module ld3320_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_d3,
  input  logic             sys_rstn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_d3) begin
    if (!sys_rstn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == (limit_i - 1'b1));

endmodule

// File: rtl/ld3320_reset_seq.sv
// LD3320 power-up / re-init sequencer: RST low pulse, recovery, CSB high pulse, done.
// Optional LD3320_RST_AUTOSTART_EN runs one sequence right after reset release.
module ld3320_reset_seq
  import ld3320_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int T_RST_LOW  = LD3320_T_RST_LOW,
  parameter int T_RECOVER  = LD3320_T_RECOVER,
  parameter int T_CSB_HIGH = LD3320_T_CSB_HIGH
) (
  input  logic               clk_d3,
  input  logic               sys_rstn,
  ld3320_reset_seq_if.slave  io
);

  localparam logic [CNT_W-1:0] LIM_RST = CNT_W'(T_RST_LOW);
  localparam logic [CNT_W-1:0] LIM_REC = CNT_W'(T_RECOVER);
  localparam logic [CNT_W-1:0] LIM_CSB = CNT_W'(T_CSB_HIGH);

  ld3320_state_e    state_q, state_d;
  ld3320_pins_t     pins_q, pins_d;
  logic             start_req;
  logic             phase_clr, phase_en, phase_term;
  logic [CNT_W-1:0] phase_lim;

`ifdef LD3320_RST_AUTOSTART_EN
  // Low only for the first cycle after reset release, which acts as an implicit ena.
  logic started_q;

  always_ff @(posedge clk_d3) begin
    if (!sys_rstn) started_q <= 1'b0;
    else           started_q <= 1'b1;
  end

  assign start_req = io.ena | ~started_q;
`else
  assign start_req = io.ena;
`endif

  always_comb begin
    phase_lim = LIM_RST;
    phase_en  = 1'b0;
    case (state_q)
      ASSERT:   begin phase_lim = LIM_RST; phase_en = 1'b1; end
      RECOVER:  begin phase_lim = LIM_REC; phase_en = 1'b1; end
      CS_PULSE: begin phase_lim = LIM_CSB; phase_en = 1'b1; end
      default:  begin phase_lim = LIM_RST; phase_en = 1'b0; end
    endcase
  end

  // Every state change restarts the count so each phase sees a fresh zero.
  assign phase_clr = (state_d != state_q);

  ld3320_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_d3   (clk_d3),
    .sys_rstn (sys_rstn),
    .clr_i    (phase_clr),
    .en_i     (phase_en),
    .limit_i  (phase_lim),
    .term_o   (phase_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_req)  state_d = ASSERT;
      ASSERT:   if (phase_term) state_d = RECOVER;
      RECOVER:  if (phase_term) state_d = CS_PULSE;
      CS_PULSE: if (phase_term) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they move on the same edge as the FSM.
  always_comb begin
    pins_d = ld3320_decode(state_d);
  end

  always_ff @(posedge clk_d3) begin
    if (!sys_rstn) begin
      state_q <= IDLE;
      pins_q  <= LD3320_PINS_IDLE;
    end else begin
      state_q <= state_d;
      pins_q  <= pins_d;
    end
  end

  assign io.RST  = pins_q.rst;
  assign io.CSB  = pins_q.csb;
  assign io.busy = pins_q.busy;
  assign io.done = pins_q.done;

endmodule

// File: tb/tb_ld3320_reset_seq.sv
// Self-checking bench for ld3320_reset_seq: default timing, minimum timing and a
// long RST pulse instance; done pulses tracked through an expected-cycle queue.
module tb_ld3320_reset_seq;

  logic clk_d3 = 1'b0;
  logic sys_rstn = 1'b0;
  logic [2:0] ena_drv = '0;
  logic [2:0][3:0] obs;   // per DUT {RST, CSB, busy, done}

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done_q[$];

  always #5 clk_d3 = ~clk_d3;
  always @(posedge clk_d3) cyc <= cyc + 1;

  ld3320_reset_seq_if if0 ();
  ld3320_reset_seq_if if1 ();
  ld3320_reset_seq_if if2 ();

  assign if0.ena = ena_drv[0];
  assign if1.ena = ena_drv[1];
  assign if2.ena = ena_drv[2];
  assign obs[0] = {if0.RST, if0.CSB, if0.busy, if0.done};
  assign obs[1] = {if1.RST, if1.CSB, if1.busy, if1.done};
  assign obs[2] = {if2.RST, if2.CSB, if2.busy, if2.done};

  ld3320_reset_seq u0 (.clk_d3(clk_d3), .sys_rstn(sys_rstn), .io(if0.slave));
  ld3320_reset_seq #(.T_RST_LOW(1), .T_RECOVER(1), .T_CSB_HIGH(1))
    u1 (.clk_d3(clk_d3), .sys_rstn(sys_rstn), .io(if1.slave));
  ld3320_reset_seq #(.CNT_W(10), .T_RST_LOW(1000))
    u2 (.clk_d3(clk_d3), .sys_rstn(sys_rstn), .io(if2.slave));

  // Expected pins "off" cycles after the start edge of a sequence.
  function automatic logic [3:0] exp_pins(int off, int t1, int t2, int t3);
    if (off < 0)                return 4'b1000;
    else if (off < t1)          return 4'b0010;
    else if (off < t1 + t2)     return 4'b1010;
    else if (off < t1 + t2 + t3) return 4'b1110;
    else if (off == t1 + t2 + t3) return 4'b1001;
    else                        return 4'b1000;
  endfunction

  task automatic step();
    @(posedge clk_d3);
    #1;
  endtask

  task automatic test_reset();
    int r;
    int e;
    logic [3:0] ex;
    sys_rstn = 1'b0;
    ena_drv  = '0;
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (obs[d] !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_state dut%0d pins=%b expected=%b", d, obs[d], 4'b1000);
      end
    end
    r = cyc;
    sys_rstn = 1'b1;
    e = r + 1;
`ifdef LD3320_RST_AUTOSTART_EN
    done_q.push_back(e + 10);
`endif
    for (int k = 0; k < 24; k++) begin
      step();
`ifdef LD3320_RST_AUTOSTART_EN
      ex = exp_pins(cyc - e, 4, 4, 2);
`else
      ex = 4'b1000;
`endif
      n_chk++;
      if (obs[0] !== ex) begin
        n_fail++;
        $display("FAIL after_reset cyc+%0d pins=%b expected=%b", cyc - e, obs[0], ex);
      end
      if (obs[0][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL after_reset_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_reset_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_single();
    int e;
    logic [3:0] ex;
    step();
    e = cyc + 1;
    ena_drv[0] = 1'b1;
    done_q.push_back(e + 10);
    for (int k = 0; k < 14; k++) begin
      step();
      ena_drv[0] = 1'b0;
      ex = exp_pins(cyc - e, 4, 4, 2);
      n_chk++;
      if (obs[0] !== ex) begin
        n_fail++;
        $display("FAIL single off=%0d pins=%b expected=%b", cyc - e, obs[0], ex);
      end
      if (obs[0][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL single_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_ignore_ena();
    int e;
    logic [3:0] ex;
    step();
    e = cyc + 1;
    ena_drv[0] = 1'b1;
    done_q.push_back(e + 10);
    for (int k = 0; k < 16; k++) begin
      step();
      ena_drv[0] = (cyc == e + 2);   // second request lands on edge e+3, mid-ASSERT
      ex = exp_pins(cyc - e, 4, 4, 2);
      n_chk++;
      if (obs[0] !== ex) begin
        n_fail++;
        $display("FAIL ignore_ena off=%0d pins=%b expected=%b", cyc - e, obs[0], ex);
      end
      if (obs[0][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL ignore_ena_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignore_ena_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_back_to_back();
    int e;
    int s;
    logic [3:0] ex;
    step();
    e = cyc + 1;
    ena_drv[0] = 1'b1;
    // 10-cycle sequence + DONE cycle + one IDLE cycle => restarts every 12 edges.
    for (int j = 0; j < 3; j++) done_q.push_back(e + 12 * j + 10);
    for (int k = 0; k < 46; k++) begin
      step();
      ena_drv[0] = (cyc + 1 <= e + 29);
      s = e;
      if (cyc >= e + 12) s = e + 12;
      if (cyc >= e + 24) s = e + 24;
      ex = exp_pins(cyc - s, 4, 4, 2);
      n_chk++;
      if (obs[0] !== ex) begin
        n_fail++;
        $display("FAIL back_to_back off=%0d pins=%b expected=%b", cyc - e, obs[0], ex);
      end
      if (obs[0][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL back_to_back_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    ena_drv[0] = 1'b0;
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_reset_mid();
    int e;
    int e2;
    logic [3:0] ex;
    step();
    e = cyc + 1;
    e2 = e + 7;
    ena_drv[0] = 1'b1;
    done_q.push_back(e2 + 10);   // the aborted sequence must not produce a done
    for (int k = 0; k < 22; k++) begin
      step();
      ena_drv[0] = (cyc == e + 6);
      sys_rstn   = !(cyc == e + 5);
      if (cyc <= e + 5)       ex = exp_pins(cyc - e, 4, 4, 2);
      else if (cyc == e + 6)  ex = 4'b1000;
      else                    ex = exp_pins(cyc - e2, 4, 4, 2);
      n_chk++;
      if (obs[0] !== ex) begin
        n_fail++;
        $display("FAIL reset_mid off=%0d pins=%b expected=%b", cyc - e, obs[0], ex);
      end
      if (obs[0][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL reset_mid_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    sys_rstn = 1'b1;
    ena_drv[0] = 1'b0;
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_min_timing();
    int e;
    logic [3:0] ex;
    step();
    e = cyc + 1;
    ena_drv[1] = 1'b1;
    done_q.push_back(e + 3);
    for (int k = 0; k < 6; k++) begin
      step();
      ena_drv[1] = 1'b0;
      ex = exp_pins(cyc - e, 1, 1, 1);
      n_chk++;
      if (obs[1] !== ex) begin
        n_fail++;
        $display("FAIL min_timing off=%0d pins=%b expected=%b", cyc - e, obs[1], ex);
      end
      if (obs[1][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL min_timing_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL min_timing_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  task automatic test_long_rst();
    int e;
    int w;
    int low_cnt;
    w = 0;
    while (obs[2][1] !== 1'b0 && w < 1200) begin
      step();
      w++;
    end
    n_chk++;
    if (obs[2][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL long_rst_idle_wait busy=%b expected=0", obs[2][1]);
    end
    step();
    e = cyc + 1;
    ena_drv[2] = 1'b1;
    done_q.push_back(e + 1006);
    low_cnt = 0;
    for (int k = 0; k < 1012; k++) begin
      step();
      ena_drv[2] = 1'b0;
      if (obs[2][3] === 1'b0) low_cnt++;
      if (cyc == e + 999 || cyc == e + 1000) begin
        n_chk++;
        if (obs[2][3] !== (cyc == e + 1000)) begin
          n_fail++;
          $display("FAIL long_rst_edge off=%0d RST=%b expected=%b", cyc - e, obs[2][3],
                   (cyc == e + 1000));
        end
      end
      if (obs[2][0] === 1'b1) begin
        n_chk++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          n_fail++;
          $display("FAIL long_rst_done at cyc %0d expected %0d", cyc,
                   (done_q.size() == 0) ? -1 : done_q[0]);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
    n_chk++;
    if (low_cnt != 1000) begin
      n_fail++;
      $display("FAIL long_rst_len low_cycles=%0d expected=1000", low_cnt);
    end
    n_chk++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_rst_missing_done pending=%0d expected=0", done_q.size());
    end
    done_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore_ena();
    test_back_to_back();
    test_reset_mid();
    test_min_timing();
    test_long_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
